// File: rtl/itch_stream_framer_if.sv
// Byte-stream bundle between the raw ITCH source, the framer and the speculative decoders.
// The slave view belongs to the framer; the master view belongs to whatever drives and observes it.
interface itch_stream_framer_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] byte_out;
    logic       valid_out;
    logic       last_out;

    modport master (
        output in_byte, in_valid,
        input  in_ready, byte_out, valid_out, last_out
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, byte_out, valid_out, last_out
    );
endinterface

// File: rtl/itch_stream_framer.sv
// Strips the 2-byte big-endian length prefix, buffers each message whole and replays it
// as one bubble-free burst followed by an idle gap, so decoders see boundaries as valid falling.
module itch_stream_framer #(
    parameter int MAX_MSG_LEN = 64,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    itch_stream_framer_if.slave        bus,
    output logic [15:0]                msg_count,
    output logic [15:0]                drop_count,
    output logic                       oversize_err
);

    localparam int IDX_W  = $clog2(MAX_MSG_LEN + 1);
    localparam int ADDR_W = (MAX_MSG_LEN > 1) ? $clog2(MAX_MSG_LEN) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        LOAD,
        DROP,
        EMIT,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        len_q;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         msg_buf [MAX_MSG_LEN];

    logic               xfer;
    logic [15:0]        full_len;
    logic [IDX_W-1:0]   msg_len;
    logic [IDX_W-1:0]   last_idx;
    logic               load_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready is gated by reset so the source never transfers during the reset cycle.
    assign bus.in_ready = rst && (state inside {LEN_HI, LEN_LO, LOAD, DROP});
    assign xfer         = bus.in_valid && bus.in_ready;
    assign full_len     = {len_q[15:8], bus.in_byte};
    assign msg_len      = len_q[IDX_W-1:0];
    assign last_idx     = msg_len - IDX_W'(1);
    assign load_done    = xfer && (state == LOAD) && (wr_idx == last_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: if (xfer) state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (full_len == 16'd0) begin
                        state_next = LEN_HI;
                    end else if (full_len > 16'(MAX_MSG_LEN)) begin
                        state_next = DROP;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD:   if (load_done) state_next = EMIT;
            DROP:   if (xfer && (len_q == 16'd1)) state_next = LEN_HI;
            EMIT:   if (rd_idx == msg_len) state_next = GAP;
            GAP:    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = LEN_HI;
            default: state_next = LEN_HI;
        endcase
    end

    // Payload storage needs no reset; a truncated message is simply overwritten.
    always_ff @(posedge clk) begin
        if (xfer && (state == LOAD)) begin
            msg_buf[wr_idx[ADDR_W-1:0]] <= bus.in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q         <= 16'd0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            gap_cnt       <= '0;
            bus.byte_out  <= 8'h00;
            bus.valid_out <= 1'b0;
            bus.last_out  <= 1'b0;
            msg_count     <= 16'd0;
            drop_count    <= 16'd0;
            oversize_err  <= 1'b0;
        end else begin
            oversize_err <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (xfer) len_q[15:8] <= bus.in_byte;
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q  <= full_len;
                        wr_idx <= '0;
                        if (full_len == 16'd0) begin
                            drop_count <= sat_inc(drop_count);
                        end else if (full_len > 16'(MAX_MSG_LEN)) begin
                            oversize_err <= 1'b1;
                            drop_count   <= sat_inc(drop_count);
                        end
                    end
                end
                LOAD: begin
                    if (xfer) wr_idx <= wr_idx + IDX_W'(1);
                    // A one-byte message is still in flight on in_byte, so bypass the buffer.
                    if (load_done) begin
                        bus.byte_out  <= (wr_idx == '0) ? bus.in_byte : msg_buf[0];
                        bus.valid_out <= 1'b1;
                        bus.last_out  <= (wr_idx == '0);
                        rd_idx        <= IDX_W'(1);
                        if (wr_idx == '0) msg_count <= sat_inc(msg_count);
                    end
                end
                DROP: begin
                    if (xfer) len_q <= len_q - 16'd1;
                end
                EMIT: begin
                    if (rd_idx == msg_len) begin
                        bus.valid_out <= 1'b0;
                        bus.last_out  <= 1'b0;
                        gap_cnt       <= '0;
                    end else begin
                        bus.byte_out  <= msg_buf[rd_idx[ADDR_W-1:0]];
                        bus.valid_out <= 1'b1;
                        bus.last_out  <= (rd_idx == last_idx);
                        rd_idx        <= rd_idx + IDX_W'(1);
                        if (rd_idx == last_idx) msg_count <= sat_inc(msg_count);
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
